// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Widths up to 16 requesters are handled by the helper functions.
package ring_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 15;
    localparam int MAXW         = 16;

    // Binary index of the set bit; zero for an all-zero vector.
    function automatic logic [3:0] onehot2bin(input logic [MAXW-1:0] v);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (v[i]) b = b | 4'(i);
        end
        return b;
    endfunction

    // Rotate the low w bits left by one, bit w-1 wrapping to bit 0.
    function automatic logic [MAXW-1:0] rotl1(input logic [MAXW-1:0] v, input int w);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < w - 1)       r[i+1] = v[i];
            else if (i == w - 1) r[0]   = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// One-hot rotating priority pointer: on advance it loads the supplied
// grant rotated left by one, so priority lands one past the last owner.
module ring_ptr
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic [N-1:0] gnt,
    output logic [N-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= N'(1);
        end else if (adv) begin
            ptr <= N'(rotl1(MAXW'(gnt), N));
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot priority ring; grants are held until release.
// Optional forced revocation after MAX_HOLD cycles when HOLD_TIMEOUT_EN is defined.
module ring_rr_arbiter
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   ptr,
    output logic           tmo,
    output state_t         state
);

    // Handshake: req is a level held until granted; the owner ends its
    // tenure with a one-cycle rel pulse or by dropping its req bit.
    state_t           nxt_state;
    logic [N-1:0]     nxt_gnt;
    logic [N-1:0]     srch_ptr;
    logic [N-1:0]     srch_req;
    logic [N-1:0]     win;
    logic [2*N-1:0]   dbl;
    logic [2*N-1:0]   low;
    logic             owner_req;
    logic             release_now;
    logic             tmo_hit;
    logic             timeout;

`ifdef HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign timeout = (hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state == BUSY && !release_now) begin
            hold_cnt <= hold_cnt + 8'd1;
        end else begin
            hold_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        owner_req   = |(req & gnt);
        release_now = (state == BUSY) && (rel || !owner_req || timeout);
        tmo_hit     = (state == BUSY) && timeout && !rel && owner_req;

        // On release the search starts one past the owner, and the owner is
        // masked so it cannot win back without an idle cycle.
        srch_ptr = release_now ? N'(rotl1(MAXW'(gnt), N)) : ptr;
        srch_req = release_now ? (req & ~gnt) : req;

        // Doubled request vector: bits at or above ptr in the low half,
        // everything in the high half, so the lowest set bit wraps correctly.
        dbl = {srch_req, srch_req} & {{N{1'b1}}, ~(srch_ptr - N'(1))};
        low = dbl & (~dbl + (2*N)'(1));
        win = low[N-1:0] | low[2*N-1:N];

        nxt_state = state;
        nxt_gnt   = gnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    nxt_gnt   = win;
                    nxt_state = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    nxt_gnt   = win;
                    nxt_state = (|win) ? BUSY : IDLE;
                end
            end
            default: begin
                nxt_gnt   = '0;
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            tmo     <= 1'b0;
        end else begin
            state   <= nxt_state;
            gnt     <= nxt_gnt;
            gnt_vld <= |nxt_gnt;
            gnt_id  <= IDW'(onehot2bin(MAXW'(nxt_gnt)));
            tmo     <= tmo_hit;
        end
    end

    ring_ptr #(
        .N(N)
    ) u_ring_ptr (
        .clk(clk),
        .rst(rst),
        .adv(release_now),
        .gnt(gnt),
        .ptr(ptr)
    );

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios plus random traffic against
// an index-based round-robin model. Honours HOLD_TIMEOUT_EN (MAX_HOLD=3).
module tb_ring_rr_arbiter;
    import ring_rr_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef HOLD_TIMEOUT_EN
    localparam int MAX_HOLD = 3;
    localparam bit TMO_EN   = 1'b1;
`else
    localparam int MAX_HOLD = 15;
    localparam bit TMO_EN   = 1'b0;
`endif
    localparam int W = 2 + N + IDW + N;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           rel;
    logic [N-1:0]   gnt;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;
    logic           tmo;
    state_t         state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;
    logic [W-1:0] exp;
    int total;
    int bad;

    // model state: owner index (-1 idle), pointer index, hold count
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_tmo;

    ring_rr_arbiter #(
        .N(N),
        .IDW(IDW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .rel(rel),
        .gnt(gnt),
        .gnt_vld(gnt_vld),
        .gnt_id(gnt_id),
        .ptr(ptr),
        .tmo(tmo),
        .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int search(input int p, input logic [N-1:0] r, input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  w;
        bit  drop;
        bit  hit;
        if (!rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                w = search(m_ptr, req, -1);
                if (w >= 0) begin
                    m_owner = w;
                    m_cnt   = 0;
                end
            end else begin
                hit  = TMO_EN && (m_cnt == MAX_HOLD);
                drop = rel || !req[m_owner] || hit;
                if (drop) begin
                    m_tmo   = hit && !rel && req[m_owner];
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = search(m_ptr, req, m_owner);
                    m_cnt   = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [N-1:0]   g;
        logic [N-1:0]   p;
        logic [IDW-1:0] id;
        g  = '0;
        id = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            id = m_owner[IDW-1:0];
        end
        p = '0;
        p[m_ptr] = 1'b1;
        return {(m_owner >= 0), m_tmo, p, id, g};
    endfunction

    // driver: apply inputs away from the edge, advance model, sample after edge
    task automatic drive(input logic r, input logic [N-1:0] q, input logic l);
        @(negedge clk);
        rst = r;
        req = q;
        rel = l;
        @(posedge clk);
        model_step();
        exp_q.push_back(model_vec());
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b1111, 1'b0);
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        total++;
        if (gnt !== 4'b0000 || ptr !== 4'b0001) begin
            bad++;
            $display("FAIL reset_const gnt=%b ptr=%b exp gnt=0000 ptr=0001", gnt, ptr);
        end
        drive(1'b1, 4'b1111, 1'b0);
        got = {gnt_vld, tmo, ptr, gnt_id, gnt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_first_grant got=%h exp=%h gnt=%b", got, exp, gnt);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(1'b0, 4'b0000, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b1, 4'b1111, 1'b0);
        void'(exp_q.pop_front());
        for (int k = 1; k < 5; k++) begin
            drive(1'b1, 4'b1111, 1'b1);
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp || gnt !== seq[k] || ptr !== seq[k]) begin
                bad++;
                $display("FAIL rotation k=%0d got=%h exp=%h gnt=%b want=%b", k, got, exp, gnt, seq[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] q [5];
        logic         l [5];
        q = '{4'b0100, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        l = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        drive(1'b0, 4'b0000, 1'b0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, q[k], l[k]);
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL wrap k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        total++;
        if (gnt !== 4'b0000 || ptr !== 4'b0100) begin
            bad++;
            $display("FAIL wrap_idle gnt=%b ptr=%b exp gnt=0000 ptr=0100", gnt, ptr);
        end
    endtask

    task automatic test_owner_drop();
        drive(1'b0, 4'b0000, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b1, 4'b0100, 1'b0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'b0000, 1'b0);
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp || gnt !== 4'b0000 || ptr !== 4'b1000) begin
                bad++;
                $display("FAIL owner_drop k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 4'b0000, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b1, 4'b1111, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b1, 4'b1111, 1'b1);
        got = {gnt_vld, tmo, ptr, gnt_id, gnt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || gnt !== 4'b0010) begin
            bad++;
            $display("FAIL reset_mid_setup got=%h exp=%h", got, exp);
        end
        drive(1'b0, 4'b1111, 1'b0);
        got = {gnt_vld, tmo, ptr, gnt_id, gnt};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp || ptr !== 4'b0001 || gnt_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_rel_idle();
        drive(1'b0, 4'b0000, 1'b0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'b0000, 1'b1);
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rel_idle k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_hold();
        int tmo_seen;
        tmo_seen = 0;
        drive(1'b0, 4'b0000, 1'b0);
        void'(exp_q.pop_front());
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 4'b0011, 1'b0);
            if (tmo === 1'b1) tmo_seen++;
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL hold k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        total++;
        if (TMO_EN ? (tmo_seen == 0) : (tmo_seen != 0)) begin
            bad++;
            $display("FAIL hold_tmo_count got=%0d timeout_enabled=%0d", tmo_seen, TMO_EN);
        end
    endtask

    task automatic test_random();
        logic         r;
        logic [N-1:0] q;
        logic         l;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 39) != 0);
            q = N'($urandom_range(0, 15));
            l = ($urandom_range(0, 3) == 0);
            drive(r, q, l);
            got = {gnt_vld, tmo, ptr, gnt_id, gnt};
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random k=%0d req=%b rel=%b rst=%b got=%h exp=%h", k, q, l, r, got, exp);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_tmo   = 1'b0;
        rst     = 1'b0;
        req     = '0;
        rel     = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_owner_drop();
        test_reset_mid();
        test_rel_idle();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
